// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle controller: stage codes, level limits,
// default stage durations and small arithmetic helpers.
package wash_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_WASH  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_SPIN  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [3:0] MIN_LEVEL = 4'd2;
   localparam logic [3:0] MAX_LEVEL = 4'd5;

   localparam int unsigned TICKS_PER_SEC_DEF   = 50_000_000;
   localparam int unsigned FILL_SEC_PER_KG_DEF = 3;
   localparam int unsigned WASH_SEC_DEF        = 20;
   localparam int unsigned DRAIN_SEC_DEF       = 5;
   localparam int unsigned SPIN_SEC_DEF        = 10;

   function automatic logic [3:0] clamp_level(input logic [3:0] lvl);
      logic [3:0] r;
      r = lvl;
      if (lvl < MIN_LEVEL) r = MIN_LEVEL;
      else if (lvl > MAX_LEVEL) r = MAX_LEVEL;
      return r;
   endfunction

   // Second counts are 8 bits wide on the display bus; anything larger pins at 255.
   function automatic logic [7:0] sat8(input int unsigned v);
      logic [7:0] r;
      r = (v > 32'd255) ? 8'hFF : v[7:0];
      return r;
   endfunction

endpackage

// File: rtl/wash_cycle_ctrl_sec_tick_gen.sv
// One-second tick divider: counts enabled clocks and pulses tick on the wrap cycle.
module sec_tick_gen
   import wash_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash cycle sequencer: latches the selected level on start, then runs
// fill/wash/drain/spin on second timers and pulses if_finish at completion.
module wash_cycle_ctrl
   import wash_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC   = TICKS_PER_SEC_DEF,
   parameter int unsigned FILL_SEC_PER_KG = FILL_SEC_PER_KG_DEF,
   parameter int unsigned WASH_SEC        = WASH_SEC_DEF,
   parameter int unsigned DRAIN_SEC       = DRAIN_SEC_DEF,
   parameter int unsigned SPIN_SEC        = SPIN_SEC_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_led,
   input  logic       start_led,
   input  logic [3:0] water_level,
   output logic       inlet_valve,
   output logic       drain_valve,
   output logic       motor_on,
   output logic       motor_fast,
   output logic [2:0] stage,
   output logic [7:0] remain_sec,
   output logic [3:0] level_latched,
   output logic       if_finish
);

   logic [2:0] stage_q, stage_d, nxt_s;
   logic [7:0] remain_q, remain_d;
   logic [3:0] level_q, level_d;
   logic       fin_q, fin_d;
   logic       start_q;
   logic       start_rise, running, tick;
   logic [3:0] lvl_c;
   logic [7:0] fill_c;

   // First stage at or after s with a non-zero duration; DONE if none remain.
   function automatic logic [2:0] first_live(input logic [2:0] s);
      logic [2:0] r;
      r = ST_DONE;
      if (s <= ST_SPIN  && SPIN_SEC  != 0) r = ST_SPIN;
      if (s <= ST_DRAIN && DRAIN_SEC != 0) r = ST_DRAIN;
      if (s <= ST_WASH  && WASH_SEC  != 0) r = ST_WASH;
      return r;
   endfunction

   function automatic logic [7:0] stage_dur(input logic [2:0] s);
      logic [7:0] r;
      case (s)
         ST_WASH:  r = sat8(WASH_SEC);
         ST_DRAIN: r = sat8(DRAIN_SEC);
         ST_SPIN:  r = sat8(SPIN_SEC);
         default:  r = 8'd0;
      endcase
      return r;
   endfunction

   assign start_rise = start_led & ~start_q;
   assign running    = (stage_q >= ST_FILL) && (stage_q <= ST_SPIN);
   assign lvl_c      = clamp_level(water_level);
   assign fill_c     = sat8(32'(lvl_c) * FILL_SEC_PER_KG);

   sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (~running),
      .en    (running & start_led & power_led),
      .tick  (tick)
   );

   always_comb begin
      stage_d  = stage_q;
      remain_d = remain_q;
      level_d  = level_q;
      fin_d    = 1'b0;
      nxt_s    = ST_DONE;
      if (!power_led) begin
         stage_d  = ST_IDLE;
         remain_d = 8'd0;
         level_d  = MIN_LEVEL;
      end else begin
         case (stage_q)
            ST_IDLE: if (start_rise) begin
               level_d  = lvl_c;
               nxt_s    = (fill_c != 8'd0) ? ST_FILL : first_live(ST_WASH);
               stage_d  = nxt_s;
               remain_d = (nxt_s == ST_FILL) ? fill_c : stage_dur(nxt_s);
            end
            ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: if (tick) begin
               if (remain_q == 8'd1) begin
                  nxt_s    = first_live(stage_q + 3'd1);
                  stage_d  = nxt_s;
                  remain_d = stage_dur(nxt_s);
               end else begin
                  remain_d = remain_q - 8'd1;
               end
            end
            default: begin
               stage_d  = ST_IDLE;
               remain_d = 8'd0;
               level_d  = MIN_LEVEL;
            end
         endcase
         // The completion pulse is registered alongside the entry into DONE.
         if (stage_d == ST_DONE && stage_q != ST_DONE) begin
            fin_d    = 1'b1;
            remain_d = 8'd0;
            level_d  = MIN_LEVEL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q  <= ST_IDLE;
         remain_q <= 8'd0;
         level_q  <= MIN_LEVEL;
         fin_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         remain_q <= remain_d;
         level_q  <= level_d;
         fin_q    <= fin_d;
         start_q  <= start_led;
      end
   end

   // Actuators follow the registered stage; a low start_led is a pause and kills them.
   assign inlet_valve   = start_led && (stage_q == ST_FILL);
   assign drain_valve   = start_led && (stage_q == ST_DRAIN || stage_q == ST_SPIN);
   assign motor_on      = start_led && (stage_q == ST_WASH  || stage_q == ST_SPIN);
   assign motor_fast    = start_led && (stage_q == ST_SPIN);
   assign stage         = stage_q;
   assign remain_sec    = remain_q;
   assign level_latched = level_q;
   assign if_finish     = fin_q;

endmodule
